skip_ctrl: RTL
==============

Name: skip_ctrl

Overview:
- Controller and arbiter for the clock-skipping ring (`skipring`) that throttles the MCS51 core clock.
- Several requesters (CPU SFR throttle, memory wait-state unit, debug) each ask for K skipped pulses per ring revolution.
- skip_ctrl grants one requester round-robin and serially builds an evenly spread LEN-bit skip mask.
- It loads the mask and a re-seed into the ring only at a revolution boundary, so the gated clock never sees a partial pattern.

Parameters:
- LEN, 16, ring length in iCLK cycles; must match the ring's LEN.
- NREQ, 3, number of requesters.
- SKW, 5, width of a skip count; must satisfy 2^SKW > LEN.
- WDOG, 32, boundary-wait watchdog in iCLK cycles; must be ≥ 2*LEN.

Ports:
- iCLK  in  1  ungated system clock.
- RST  in  1  reset; asynchronous, active-high.
- REQ  in  NREQ  per-requester throttle request, level-held.
- REQSKIP  in  NREQ*SKW  requested skip count per requester; slice i = [i*SKW +: SKW].
- GNT  out  NREQ  one-hot grant.
- B0  in  1  ring position-0 flag, from the ring's oB0.
- ringRST  out  1  ring reload strobe, to the ring's RST.
- ringE  out  1  ring rotate enable, to the ring's E.
- ringSEL  out  LEN  ring reload pattern, to the ring's rSEL.
- ringMASK  out  LEN  active skip mask, to the ring's MASK.
- BUSY  out  1  high in every state except IDLE.
- CURSKIP  out  SKW  K currently applied in ringMASK.

Behaviour:
- Reset values, applied asynchronously:
  - GNT = 0, ringRST = 0, ringE = 1, ringMASK = 0, CURSKIP = 0, BUSY = 0.
  - Round-robin pointer = 0; state = IDLE.
- ringSEL is the constant LEN'b1.
- Reset mid-operation: ringMASK drops to 0 immediately, so the ring runs ungated. Any partially built mask is discarded.
- All other registers update on posedge iCLK.
- Clamp rule: K = min(REQSKIP slice, LEN-1). At least one pulse per revolution always passes, so the CPU is never fully stalled.
- Mask generation (serial, one bit per cycle, LEN cycles):
  - acc starts at 0. For i = 0..LEN-1: acc += K; if acc ≥ LEN then acc -= LEN and pend[i] = 1, else pend[i] = 0.
  - acc width is SKW+1.
  - K = 0 gives pend = 0.
- States:
  - IDLE: if any REQ is high, go to ARB.
  - ARB (1 cycle):
    - Select the first set REQ at or after the pointer, wrapping.
    - Set GNT for the winner; latch K and Kraw (the unclamped slice).
    - Pointer = winner+1 mod NREQ. Go to BUILD.
  - BUILD (LEN cycles): produce pend. Then go to WAITB0.
  - WAITB0:
    - Wait for B0 = 1 sampled on posedge, then go to LOAD.
    - If B0 is not seen within WDOG cycles, go to LOAD anyway (recovery).
  - LOAD (1 cycle):
    - ringRST = 1, ringMASK <= pend, CURSKIP <= K.
    - Next state is RUN, or IDLE if this load was a release.
  - RUN:
    - If REQ[g] falls: pend = 0, K = 0, mark release, go to WAITB0. GNT clears on the LOAD→IDLE transition.
    - Else if REQSKIP[g] ≠ Kraw: re-latch, go to BUILD.
- Arbitration:
  - Non-preemptive: other requests wait while the grant is held.
  - Simultaneous requests are resolved by the pointer only.
  - A REQ drop during BUILD or WAITB0 is handled at RUN entry; RUN releases on the next cycle.
- Latency: REQ rise to ringRST pulse = 1 (ARB) + LEN (BUILD) + at most LEN (WAITB0) cycles.
- ringRST is exactly one cycle wide. ringMASK changes only in the LOAD cycle or on reset.

Optional Feature:
- SKIPCTL_CNT_EN defined:
  - Adds output SKIPCNT [15:0] and input CNTCLR.
  - On every B0 = 1 cycle in RUN, SKIPCNT += CURSKIP, saturating at 16'hFFFF.
  - CNTCLR = 1 or reset sets SKIPCNT to 0; CNTCLR wins over an increment in the same cycle.
- Not defined: neither port exists; there is no counter logic.

Decomposition:
- Package skipctl_pkg holds:
  - LEN / SKW defaults;
  - the state encoding (IDLE, ARB, BUILD, WAITB0, LOAD, RUN);
  - the clamp function.
- Sub-module skip_maskgen holds the serial accumulator.
  - Inputs: start, K.
  - Outputs: pend[LEN-1:0], done (asserted after LEN cycles).

Test Plan:
1. REQ=3'b001, REQSKIP[0]=4, ring B0 free-running → after ≤ 33 cycles one ringRST pulse; ringMASK = 16'h8888; CURSKIP = 4; GNT = 3'b001.
2. REQSKIP[0]=8 → ringMASK = 16'hAAAA. REQSKIP[0]=16 → clamped, ringMASK = 16'hFFFE, CURSKIP = 15.
3. REQ=3'b111 held, each dropped after one load → grants in order 001, 010, 100, 001. ringMASK returns to 0 between holders.
4. In RUN, change REQSKIP[0] 4→2 → rebuild; ringMASK = 16'h8080 loaded exactly in a cycle where B0 = 1.
5. B0 tied to 0 → LOAD occurs WDOG cycles after entering WAITB0. RST asserted mid-BUILD → ringMASK = 0, GNT = 0 asynchronously.
6. With SKIPCTL_CNT_EN, K=4 held for 10 revolutions → SKIPCNT = 40. CNTCLR coinciding with B0 → SKIPCNT = 0.

Source files
------------

// File: rtl/skipctl_pkg.sv
// Shared definitions for the clock-skip ring controller: default sizes,
// FSM state encoding and the skip-count clamp.
package skipctl_pkg;

  localparam int unsigned LEN_DEF = 16;
  localparam int unsigned SKW_DEF = 5;

  typedef enum logic [2:0] {
    StIdle,
    StArb,
    StBuild,
    StWaitb0,
    StLoad,
    StRun
  } state_e;

  // Never skip a whole revolution: at least one core pulse always passes.
  function automatic logic [31:0] clamp_skip(input logic [31:0] raw, input logic [31:0] len);
    return (raw >= len) ? (len - 32'd1) : raw;
  endfunction

endpackage

// File: rtl/skip_maskgen.sv
// Serial Bresenham-style spreader: builds an evenly distributed LEN-bit skip
// mask with K ones, one bit per cycle, starting the cycle after start.
module skip_maskgen #(
  parameter int unsigned LEN = 16,
  parameter int unsigned SKW = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [SKW-1:0] k,
  output logic [LEN-1:0] pend,
  output logic           done
);

  localparam int unsigned IW = (LEN > 1) ? $clog2(LEN) : 1;

  logic          active_q;
  logic [IW-1:0] idx_q;
  logic [SKW:0]  acc_q;
  logic [SKW:0]  sum;
  logic          hit;

  // Accumulator step and last-bit detect for the current position.
  always_comb begin
    sum  = acc_q + {1'b0, k};
    hit  = (sum >= (SKW+1)'(LEN));
    done = active_q && (idx_q == IW'(LEN - 1));
  end

  // Walk LEN positions after start, emitting one mask bit per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q <= 1'b0;
      idx_q    <= '0;
      acc_q    <= '0;
      pend     <= '0;
    end else if (start) begin
      active_q <= 1'b1;
      idx_q    <= '0;
      acc_q    <= '0;
      pend     <= '0;
    end else if (active_q) begin
      pend[idx_q] <= hit;
      acc_q       <= hit ? (sum - (SKW+1)'(LEN)) : sum;
      idx_q       <= idx_q + 1'b1;
      if (done) begin
        active_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/skip_ctrl.sv
// Round-robin arbiter and loader for the clock-skipping ring. Builds a skip
// mask for the granted requester and swaps it into the ring only at a
// revolution boundary (B0) so the gated clock never sees a partial pattern.
// Optional SKIPCTL_CNT_EN adds a saturating skipped-pulse counter (SKIPCNT)
// with a synchronous clear (CNTCLR).
module skip_ctrl
  import skipctl_pkg::*;
#(
  parameter int unsigned LEN  = LEN_DEF,
  parameter int unsigned NREQ = 3,
  parameter int unsigned SKW  = SKW_DEF,
  parameter int unsigned WDOG = 32
) (
  input  logic              iCLK,
  input  logic              RST,
  input  logic [NREQ-1:0]   REQ,
  input  logic [NREQ*SKW-1:0] REQSKIP,
  output logic [NREQ-1:0]   GNT,
  input  logic              B0,
  output logic              ringRST,
  output logic              ringE,
  output logic [LEN-1:0]    ringSEL,
  output logic [LEN-1:0]    ringMASK,
  output logic              BUSY,
  output logic [SKW-1:0]    CURSKIP
`ifdef SKIPCTL_CNT_EN
  ,
  input  logic              CNTCLR,
  output logic [15:0]       SKIPCNT
`endif
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned WW = (WDOG > 1) ? $clog2(WDOG) : 1;

  state_e          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   g_q, g_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [SKW-1:0]  k_q, k_d;
  logic [SKW-1:0]  kraw_q, kraw_d;
  logic            rel_q, rel_d;
  logic [WW-1:0]   wd_q, wd_d;
  logic [LEN-1:0]  mask_q;
  logic [SKW-1:0]  cur_q;
  logic            ringrst_q;

  logic            start;
  logic [LEN-1:0]  pend;
  logic            done;
  logic            win_found;
  logic [PW-1:0]   win_idx;
  logic [SKW-1:0]  win_skip;
  logic            req_g;
  logic [SKW-1:0]  skip_g;

  skip_maskgen #(
    .LEN (LEN),
    .SKW (SKW)
  ) u_maskgen (
    .clk   (iCLK),
    .rst   (RST),
    .start (start),
    .k     (k_q),
    .pend  (pend),
    .done  (done)
  );

  // First pending request at or after the pointer, wrapping; plus granted slice.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      int j;
      j = (int'(ptr_q) + i) % int'(NREQ);
      if (!win_found && REQ[j]) begin
        win_found = 1'b1;
        win_idx   = PW'(j);
      end
    end
    win_skip = REQSKIP[win_idx*SKW +: SKW];
    req_g    = REQ[g_q];
    skip_g   = REQSKIP[g_q*SKW +: SKW];
  end

  // Next-state and datapath updates for the controller FSM.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    g_d     = g_q;
    gnt_d   = gnt_q;
    k_d     = k_q;
    kraw_d  = kraw_q;
    rel_d   = rel_q;
    wd_d    = wd_q;
    start   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|REQ) state_d = StArb;
      end
      StArb: begin
        if (win_found) begin
          gnt_d   = NREQ'(1) << win_idx;
          g_d     = win_idx;
          kraw_d  = win_skip;
          k_d     = SKW'(clamp_skip(32'(win_skip), 32'(LEN)));
          ptr_d   = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
          rel_d   = 1'b0;
          start   = 1'b1;
          state_d = StBuild;
        end else begin
          // Request vanished before arbitration; nothing to grant.
          state_d = StIdle;
        end
      end
      StBuild: begin
        if (done) begin
          wd_d    = '0;
          state_d = StWaitb0;
        end
      end
      StWaitb0: begin
        if (B0 || (wd_q == WW'(WDOG - 1))) begin
          state_d = StLoad;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      StLoad: begin
        if (rel_q) begin
          gnt_d   = '0;
          state_d = StIdle;
        end else begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (!req_g) begin
          // Release: load an all-pass mask at the next boundary, then idle.
          rel_d   = 1'b1;
          k_d     = '0;
          wd_d    = '0;
          state_d = StWaitb0;
        end else if (skip_g != kraw_q) begin
          kraw_d  = skip_g;
          k_d     = SKW'(clamp_skip(32'(skip_g), 32'(LEN)));
          start   = 1'b1;
          state_d = StBuild;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Controller state registers.
  always_ff @(posedge iCLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      g_q     <= '0;
      gnt_q   <= '0;
      k_q     <= '0;
      kraw_q  <= '0;
      rel_q   <= 1'b0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      g_q     <= g_d;
      gnt_q   <= gnt_d;
      k_q     <= k_d;
      kraw_q  <= kraw_d;
      rel_q   <= rel_d;
      wd_q    <= wd_d;
    end
  end

  // Ring-facing registers: mask and applied K change only when leaving LOAD.
  always_ff @(posedge iCLK or posedge RST) begin
    if (RST) begin
      mask_q    <= '0;
      cur_q     <= '0;
      ringrst_q <= 1'b0;
    end else begin
      ringrst_q <= (state_d == StLoad);
      if (state_q == StLoad) begin
        mask_q <= rel_q ? '0 : pend;
        cur_q  <= k_q;
      end
    end
  end

  assign GNT      = gnt_q;
  assign ringRST  = ringrst_q;
  assign ringE    = 1'b1;
  assign ringSEL  = LEN'(1);
  assign ringMASK = mask_q;
  assign BUSY     = (state_q != StIdle);
  assign CURSKIP  = cur_q;

`ifdef SKIPCTL_CNT_EN
  logic [15:0] cnt_q;
  logic [16:0] cnt_sum;

  assign cnt_sum = {1'b0, cnt_q} + 17'(cur_q);

  // Accumulate skipped pulses once per revolution while running; clear wins.
  always_ff @(posedge iCLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
    end else if (CNTCLR) begin
      cnt_q <= '0;
    end else if ((state_q == StRun) && B0) begin
      cnt_q <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end
  end

  assign SKIPCNT = cnt_q;
`endif

endmodule
